// File: rtl/hyperbus_pkg.sv
// Shared types for the HyperBus transceiver sequencer.
// Holds the FSM encoding, CA layout and CA word selection.
package hyperbus_pkg;

  typedef enum logic [2:0] {
    SeqIdle,
    SeqCsSetup,
    SeqCa,
    SeqLat,
    SeqWr,
    SeqRd,
    SeqCsHold,
    SeqCsGap
  } seq_state_e;

  localparam int unsigned CaWords = 3;

  typedef struct packed {
    logic        rw;
    logic        as;
    logic        burst;
    logic [44:0] addr;
  } hyper_ca_t;

  // CA goes out most-significant word first
  function automatic logic [15:0] ca_word(
    input hyper_ca_t  ca,
    input logic [1:0] idx
  );
    logic [47:0] raw;
    logic [15:0] w;
    raw = ca;
    unique case (idx)
      2'd0:    w = raw[47:32];
      2'd1:    w = raw[31:16];
      default: w = raw[15:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/hyperbus_trx_credit.sv
// Read-burst bookkeeping: clock issue vs. received words,
// RX FIFO credit limit and inter-word timeout.
module hyperbus_trx_credit
  import hyperbus_pkg::*;
#(
  parameter int unsigned LenWidth      = 16,
  parameter int unsigned RxCredits     = 8,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                active_i,
  input  logic [LenWidth-1:0] len_i,
  input  logic                rx_fire_i,
  output logic                issue_o,
  output logic                last_o,
  output logic                done_o,
  output logic                timeout_o
);

  localparam int unsigned TW = $clog2(TimeoutCycles + 1);

  logic [LenWidth-1:0] issued_q, issued_d;
  logic [LenWidth-1:0] recvd_q, recvd_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [LenWidth-1:0] inflight;
  logic                fire;

  assign inflight  = issued_q - recvd_q;
  assign fire      = active_i && rx_fire_i && (recvd_q != len_i);
  assign issue_o   = active_i && (issued_q < len_i)
                     && (32'(inflight) < RxCredits);
  assign done_o    = active_i && (recvd_q == len_i);
  assign last_o    = active_i && (recvd_q == len_i - 1'b1);
  assign timeout_o = active_i && !done_o
                     && (tmo_q == TW'(TimeoutCycles));

  always_comb begin
    issued_d = issued_q;
    recvd_d  = recvd_q;
    tmo_d    = tmo_q;
    if (!active_i) begin
      issued_d = '0;
      recvd_d  = '0;
      tmo_d    = '0;
    end else begin
      if (issue_o && !timeout_o) issued_d = issued_q + 1'b1;
      if (fire) begin
        recvd_d = recvd_q + 1'b1;
        tmo_d   = '0;
      end else if (!timeout_o) begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issued_q <= '0;
      recvd_q  <= '0;
      tmo_q    <= '0;
    end else begin
      issued_q <= issued_d;
      recvd_q  <= recvd_d;
      tmo_q    <= tmo_d;
    end
  end

endmodule

// File: rtl/hyperbus_trx_seq.sv
// HyperBus transaction sequencer driving the PHY transceiver
// control lines: CS, clock enable, output enables, RX clock gate.
module hyperbus_trx_seq
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumChips      = 2,
  parameter int unsigned LenWidth      = 16,
  parameter int unsigned RxCredits     = 8,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned CshWidth      = 4,
  localparam int unsigned CsW = (NumChips > 1) ? $clog2(NumChips) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [47:0]         cmd_ca_i,
  input  logic [CsW-1:0]      cmd_cs_i,
  input  logic [LenWidth-1:0] cmd_len_i,
  input  logic [3:0]          cfg_latency_i,
  input  logic                cfg_fixed_lat_i,
  input  logic [CshWidth-1:0] cfg_t_csh_i,
  input  logic                tx_valid_i,
  output logic                tx_ready_o,
  input  logic [15:0]         tx_data_i,
  input  logic [1:0]          tx_strb_i,
  input  logic                rx_valid_i,
  output logic                rx_ready_o,
  input  logic [15:0]         rx_data_i,
  output logic                rx_valid_o,
  input  logic                rx_ready_i,
  output logic [15:0]         rx_data_o,
  output logic                rx_last_o,
  output logic                done_o,
  output logic                err_o,
  output logic [NumChips-1:0] trx_cs_o,
  output logic                trx_cs_ena_o,
  input  logic                trx_rwds_sample_i,
  output logic                trx_rwds_sample_ena_o,
  output logic                trx_tx_clk_ena_o,
  output logic [15:0]         trx_tx_data_o,
  output logic                trx_tx_data_oe_o,
  output logic [1:0]          trx_tx_rwds_o,
  output logic                trx_tx_rwds_oe_o,
  output logic                trx_rx_clk_set_o,
  output logic                trx_rx_clk_reset_o
);

  localparam int unsigned CntA = (LenWidth > CshWidth) ? LenWidth : CshWidth;
  localparam int unsigned CntW = (CntA > 5) ? CntA : 5;

  seq_state_e          state_q, state_d;
  hyper_ca_t           ca_q, ca_d;
  logic [CsW-1:0]      cs_q, cs_d;
  logic [LenWidth-1:0] len_q, len_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                extra_q, extra_d;
  logic                abort_q, abort_d;
  logic                first_q, first_d;

  logic                rd_issue, rd_last, rd_done, rd_tmo;
  logic [4:0]          lat_n;
  logic [CshWidth-1:0] csh_n;
  logic                is_wr;

  assign rx_data_o  = rx_data_i;
  assign rx_valid_o = rx_valid_i;
  assign rx_ready_o = rx_ready_i;
  assign rx_last_o  = rd_last;

  assign is_wr = ~ca_q.rw;
  assign lat_n = {1'b0, cfg_latency_i} << extra_q;
  assign csh_n = (cfg_t_csh_i == '0) ? CshWidth'(1) : cfg_t_csh_i;

  hyperbus_trx_credit #(
    .LenWidth      (LenWidth),
    .RxCredits     (RxCredits),
    .TimeoutCycles (TimeoutCycles)
  ) u_credit (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .active_i  (state_q == SeqRd),
    .len_i     (len_q),
    .rx_fire_i (rx_valid_i && rx_ready_i),
    .issue_o   (rd_issue),
    .last_o    (rd_last),
    .done_o    (rd_done),
    .timeout_o (rd_tmo)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SeqIdle;
      ca_q    <= '0;
      cs_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      extra_q <= 1'b0;
      abort_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ca_q    <= ca_d;
      cs_q    <= cs_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      extra_q <= extra_d;
      abort_q <= abort_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ca_d    = ca_q;
    cs_d    = cs_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    extra_d = extra_q;
    abort_d = abort_q;
    first_d = 1'b0;
    unique case (state_q)
      SeqIdle: begin
        if (cmd_valid_i) begin
          ca_d    = cmd_ca_i;
          cs_d    = cmd_cs_i;
          len_d   = (cmd_len_i == '0) ? LenWidth'(1) : cmd_len_i;
          abort_d = 1'b0;
          cnt_d   = '0;
          state_d = SeqCsSetup;
        end
      end
      SeqCsSetup: begin
        cnt_d   = '0;
        state_d = SeqCa;
      end
      SeqCa: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(CaWords - 1)) begin
          extra_d = trx_rwds_sample_i | cfg_fixed_lat_i;
          cnt_d   = '0;
          if (cfg_latency_i != '0) begin
            state_d = SeqLat;
          end else begin
            state_d = is_wr ? SeqWr : SeqRd;
            first_d = ~is_wr;
          end
        end
      end
      SeqLat: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(lat_n - 1'b1)) begin
          cnt_d   = '0;
          state_d = is_wr ? SeqWr : SeqRd;
          first_d = ~is_wr;
        end
      end
      SeqWr: begin
        if (tx_valid_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(len_q - 1'b1)) state_d = SeqCsHold;
        end
      end
      SeqRd: begin
        if (rd_done) begin
          state_d = SeqCsHold;
        end else if (rd_tmo) begin
          abort_d = 1'b1;
          state_d = SeqCsHold;
        end
      end
      SeqCsHold: begin
        cnt_d   = '0;
        state_d = SeqCsGap;
      end
      SeqCsGap: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(csh_n - 1'b1)) state_d = SeqIdle;
      end
      default: state_d = SeqIdle;
    endcase
  end

  always_comb begin
    cmd_ready_o           = 1'b0;
    tx_ready_o            = 1'b0;
    done_o                = 1'b0;
    err_o                 = 1'b0;
    trx_cs_ena_o          = 1'b0;
    trx_cs_o              = '0;
    trx_rwds_sample_ena_o = 1'b0;
    trx_tx_clk_ena_o      = 1'b0;
    trx_tx_data_o         = '0;
    trx_tx_data_oe_o      = 1'b0;
    trx_tx_rwds_o         = '0;
    trx_tx_rwds_oe_o      = 1'b0;
    trx_rx_clk_set_o      = 1'b0;
    trx_rx_clk_reset_o    = 1'b0;
    unique case (state_q)
      SeqIdle: cmd_ready_o = 1'b1;
      SeqCsSetup: trx_cs_ena_o = 1'b1;
      SeqCa: begin
        trx_cs_ena_o          = 1'b1;
        trx_tx_clk_ena_o      = 1'b1;
        trx_tx_data_oe_o      = 1'b1;
        trx_rwds_sample_ena_o = 1'b1;
        trx_tx_data_o         = ca_word(ca_q, cnt_q[1:0]);
      end
      SeqLat: begin
        trx_cs_ena_o     = 1'b1;
        trx_tx_clk_ena_o = 1'b1;
      end
      SeqWr: begin
        trx_cs_ena_o     = 1'b1;
        tx_ready_o       = 1'b1;
        trx_tx_data_o    = tx_data_i;
        trx_tx_rwds_o    = ~tx_strb_i;
        trx_tx_data_oe_o = 1'b1;
        trx_tx_rwds_oe_o = 1'b1;
        // no data: stop the clock, keep driving the bus
        trx_tx_clk_ena_o = tx_valid_i;
      end
      SeqRd: begin
        trx_cs_ena_o       = 1'b1;
        trx_tx_clk_ena_o   = rd_issue && !rd_tmo;
        trx_rx_clk_set_o   = first_q;
        trx_rx_clk_reset_o = rd_done || rd_tmo;
        err_o              = rd_tmo;
      end
      SeqCsHold: begin
        trx_cs_ena_o = 1'b1;
        done_o       = ~abort_q;
      end
      default: ;
    endcase
    if (trx_cs_ena_o) trx_cs_o = NumChips'(1) << cs_q;
  end

endmodule

// File: tb/tb_hyperbus_trx_seq.sv
// Directed bench for hyperbus_trx_seq with a small PHY RX FIFO
// model that returns one word per issued read clock.
module tb_hyperbus_trx_seq;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [47:0] cmd_ca_i = '0;
  logic [0:0]  cmd_cs_i = '0;
  logic [15:0] cmd_len_i = '0;
  logic [3:0]  cfg_latency_i = 4'd6;
  logic        cfg_fixed_lat_i = 1'b0;
  logic [3:0]  cfg_t_csh_i = 4'd3;
  logic        tx_valid_i = 1'b0;
  logic        tx_ready_o;
  logic [15:0] tx_data_i = '0;
  logic [1:0]  tx_strb_i = '0;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [15:0] rx_data_i = '0;
  logic        rx_valid_o;
  logic        rx_ready_i = 1'b1;
  logic [15:0] rx_data_o;
  logic        rx_last_o;
  logic        done_o, err_o;
  logic [1:0]  trx_cs_o;
  logic        trx_cs_ena_o;
  logic        trx_rwds_sample_i = 1'b0;
  logic        trx_rwds_sample_ena_o;
  logic        trx_tx_clk_ena_o;
  logic [15:0] trx_tx_data_o;
  logic        trx_tx_data_oe_o;
  logic [1:0]  trx_tx_rwds_o;
  logic        trx_tx_rwds_oe_o;
  logic        trx_rx_clk_set_o, trx_rx_clk_reset_o;

  always #5 clk = ~clk;

  hyperbus_trx_seq dut (
    .clk_i                 (clk),
    .rst_ni                (rst_ni),
    .cmd_valid_i           (cmd_valid_i),
    .cmd_ready_o           (cmd_ready_o),
    .cmd_ca_i              (cmd_ca_i),
    .cmd_cs_i              (cmd_cs_i),
    .cmd_len_i             (cmd_len_i),
    .cfg_latency_i         (cfg_latency_i),
    .cfg_fixed_lat_i       (cfg_fixed_lat_i),
    .cfg_t_csh_i           (cfg_t_csh_i),
    .tx_valid_i            (tx_valid_i),
    .tx_ready_o            (tx_ready_o),
    .tx_data_i             (tx_data_i),
    .tx_strb_i             (tx_strb_i),
    .rx_valid_i            (rx_valid_i),
    .rx_ready_o            (rx_ready_o),
    .rx_data_i             (rx_data_i),
    .rx_valid_o            (rx_valid_o),
    .rx_ready_i            (rx_ready_i),
    .rx_data_o             (rx_data_o),
    .rx_last_o             (rx_last_o),
    .done_o                (done_o),
    .err_o                 (err_o),
    .trx_cs_o              (trx_cs_o),
    .trx_cs_ena_o          (trx_cs_ena_o),
    .trx_rwds_sample_i     (trx_rwds_sample_i),
    .trx_rwds_sample_ena_o (trx_rwds_sample_ena_o),
    .trx_tx_clk_ena_o      (trx_tx_clk_ena_o),
    .trx_tx_data_o         (trx_tx_data_o),
    .trx_tx_data_oe_o      (trx_tx_data_oe_o),
    .trx_tx_rwds_o         (trx_tx_rwds_o),
    .trx_tx_rwds_oe_o      (trx_tx_rwds_oe_o),
    .trx_rx_clk_set_o      (trx_rx_clk_set_o),
    .trx_rx_clk_reset_o    (trx_rx_clk_reset_o)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // per-transaction observations, cleared at each accepted command
  int          ca_n, lat_n, rd_n, beats, stall_n, gap_n;
  int          done_n, err_n, set_n, rst_cnt;
  logic        rd_phase;
  logic [1:0]  cs_seen;
  logic [15:0] ca_w [3];
  logic [15:0] rx_words [$];
  logic        rx_lasts [$];
  logic [15:0] wr_data [$];
  logic [1:0]  wr_rwds [$];
  logic        fire_n, issue_n, setp_n;

  always @(negedge clk) begin
    if (!rst_ni) begin
      rd_phase = 1'b0;
      fire_n   = 1'b0;
      issue_n  = 1'b0;
      setp_n   = 1'b0;
    end else begin
      if (cmd_valid_i && cmd_ready_o) begin
        ca_n = 0; lat_n = 0; rd_n = 0; beats = 0; stall_n = 0;
        gap_n = 0; done_n = 0; err_n = 0; set_n = 0; rst_cnt = 0;
        cs_seen = '0;
        rx_words.delete(); rx_lasts.delete();
        wr_data.delete(); wr_rwds.delete();
      end
      setp_n = trx_rx_clk_set_o;
      if (trx_rx_clk_set_o) begin
        rd_phase = 1'b1;
        set_n++;
      end
      if (trx_cs_ena_o) cs_seen = cs_seen | trx_cs_o;
      if (trx_tx_clk_ena_o && trx_tx_data_oe_o && !trx_tx_rwds_oe_o) begin
        if (ca_n < 3) ca_w[ca_n] = trx_tx_data_o;
        ca_n++;
      end
      if (trx_tx_clk_ena_o && !trx_tx_data_oe_o && !rd_phase) lat_n++;
      issue_n = trx_tx_clk_ena_o && rd_phase;
      if (issue_n) rd_n++;
      if (tx_ready_o && tx_valid_i && trx_tx_clk_ena_o) begin
        beats++;
        wr_data.push_back(trx_tx_data_o);
        wr_rwds.push_back(trx_tx_rwds_o);
      end
      if (tx_ready_o && !trx_tx_clk_ena_o && trx_tx_data_oe_o) stall_n++;
      fire_n = rx_valid_i && rx_ready_i;
      if (rx_valid_o && rx_ready_i) begin
        rx_words.push_back(rx_data_o);
        rx_lasts.push_back(rx_last_o);
      end
      if (done_o) done_n++;
      if (err_o) err_n++;
      if (!trx_cs_ena_o && !cmd_ready_o) gap_n++;
      if (trx_rx_clk_reset_o) begin
        rst_cnt++;
        rd_phase = 1'b0;
      end
    end
  end

  // PHY RX FIFO: each issued read clock yields word A000+n next cycle
  logic        phy_mute = 1'b0;
  logic [15:0] phy_q [$];
  logic [15:0] widx = '0;

  always @(posedge clk) begin
    #1;
    if (!rst_ni) begin
      phy_q.delete();
    end else begin
      if (setp_n) widx = '0;
      if (fire_n && phy_q.size() != 0) void'(phy_q.pop_front());
      if (issue_n && !phy_mute) begin
        phy_q.push_back(16'hA000 + widx);
        widx = widx + 16'd1;
      end
    end
    rx_valid_i = phy_q.size() != 0;
    rx_data_i  = (phy_q.size() != 0) ? phy_q[0] : 16'h0;
  end

  logic [47:0] exp_ca;

  task automatic send_cmd(input logic [47:0] ca, input logic cs,
                          input logic [15:0] len);
    int n;
    n = 0;
    exp_ca = ca;
    @(negedge clk); #1;
    while (!cmd_ready_o && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    cmd_valid_i = 1'b1;
    cmd_ca_i    = ca;
    cmd_cs_i    = cs;
    cmd_len_i   = len;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int limit);
    int n;
    n = 0;
    while (!((done_n + err_n) != 0 && cmd_ready_o) && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_in_time"}, n < limit, 1'b1);
  endtask

  task automatic check_ca(input string tag);
    check({tag, "_ca_n"}, ca_n, 3);
    check({tag, "_ca0"}, ca_w[0], exp_ca[47:32]);
    check({tag, "_ca1"}, ca_w[1], exp_ca[31:16]);
    check({tag, "_ca2"}, ca_w[2], exp_ca[15:0]);
  endtask

  task automatic check_read(input string tag, input logic cs,
                            input int len, input int exp_lat);
    check_ca(tag);
    check({tag, "_lat"}, lat_n, exp_lat);
    check({tag, "_clks"}, rd_n, len);
    check({tag, "_rxset"}, set_n, 1);
    check({tag, "_rxrst"}, rst_cnt, 1);
    check({tag, "_done"}, done_n, 1);
    check({tag, "_err"}, err_n, 0);
    check({tag, "_gap"}, gap_n, 3);
    check({tag, "_cs"}, cs_seen, cs ? 2'b10 : 2'b01);
    check({tag, "_nwords"}, rx_words.size(), len);
    for (int i = 0; i < len && i < rx_words.size(); i++) begin
      check({tag, "_word"}, rx_words[i], 16'hA000 + 16'(i));
      check({tag, "_last"}, rx_lasts[i], i == len - 1);
    end
  endtask

  localparam logic [47:0] CaRd = {1'b1, 2'b01, 45'h0_1234_5678};
  localparam logic [47:0] CaWr = {1'b0, 2'b01, 45'h0_0ABC_DEF0};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready_o, 1'b1);
    check("rst_cs", trx_cs_o, 2'b00);
    check("rst_cs_ena", trx_cs_ena_o, 1'b0);
    check("rst_clk_ena", trx_tx_clk_ena_o, 1'b0);
    check("rst_oe", {trx_tx_data_oe_o, trx_tx_rwds_oe_o}, 2'b00);
    check("rst_pulses", {done_o, err_o, trx_rx_clk_set_o}, 3'b000);
    rst_ni = 1'b1;

    send_cmd(CaRd, 1'b1, 16'd4);
    wait_end("rd4", 500);
    check_read("rd4", 1'b1, 4, 6);

    trx_rwds_sample_i = 1'b1;
    send_cmd(CaRd, 1'b0, 16'd4);
    wait_end("rd_rwds", 500);
    check_read("rd_rwds", 1'b0, 4, 12);
    trx_rwds_sample_i = 1'b0;

    cfg_fixed_lat_i = 1'b1;
    send_cmd(CaRd, 1'b1, 16'd4);
    wait_end("rd_fixed", 500);
    check_read("rd_fixed", 1'b1, 4, 12);
    cfg_fixed_lat_i = 1'b0;

    // write, zero latency, two stall cycles after the first beat
    cfg_latency_i = 4'd0;
    tx_valid_i = 1'b1;
    tx_strb_i  = 2'b01;
    tx_data_i  = 16'hD000;
    send_cmd(CaWr, 1'b0, 16'd3);
    begin
      int n;
      n = 0;
      while (!tx_ready_o && n < 100) begin
        @(negedge clk); #1;
        n++;
      end
    end
    @(posedge clk); #1;
    tx_valid_i = 1'b0;
    tx_data_i  = 16'hD001;
    @(posedge clk);
    @(posedge clk); #1;
    tx_valid_i = 1'b1;
    @(posedge clk); #1;
    tx_data_i = 16'hD002;
    wait_end("wr3", 500);
    check_ca("wr3");
    check("wr3_lat", lat_n, 0);
    check("wr3_beats", beats, 3);
    check("wr3_stall", stall_n, 2);
    check("wr3_done", done_n, 1);
    check("wr3_rxset", set_n, 0);
    check("wr3_gap", gap_n, 3);
    for (int i = 0; i < 3 && i < wr_data.size(); i++) begin
      check("wr3_data", wr_data[i], 16'hD000 + 16'(i));
      check("wr3_rwds", wr_rwds[i], 2'b10);
    end

    // length 0 behaves as a single word
    tx_strb_i = 2'b11;
    tx_data_i = 16'h5A5A;
    send_cmd(CaWr, 1'b1, 16'd0);
    wait_end("wr0", 500);
    check("wr0_beats", beats, 1);
    check("wr0_rwds", wr_rwds.size() != 0 ? wr_rwds[0] : 2'b11, 2'b00);
    check("wr0_done", done_n, 1);
    tx_valid_i = 1'b0;
    cfg_latency_i = 4'd6;

    // credit limit with the consumer stalled
    rx_ready_i = 1'b0;
    send_cmd(CaRd, 1'b0, 16'd20);
    repeat (80) @(negedge clk);
    #1;
    check("cred_issued", rd_n, 8);
    check("cred_clk_off", trx_tx_clk_ena_o, 1'b0);
    check("cred_nwords", rx_words.size(), 0);
    @(posedge clk); #1;
    rx_ready_i = 1'b1;
    wait_end("cred", 1000);
    check_read("cred", 1'b0, 20, 6);

    // no RX data at all: abort after the timeout
    phy_mute = 1'b1;
    send_cmd(CaRd, 1'b1, 16'd4);
    wait_end("tmo", 1500);
    check("tmo_err", err_n, 1);
    check("tmo_done", done_n, 0);
    check("tmo_rxrst", rst_cnt, 1);
    check("tmo_clks", rd_n, 4);
    check("tmo_idle", cmd_ready_o, 1'b1);
    phy_mute = 1'b0;

    // reset in the middle of the CA phase
    send_cmd(CaRd, 1'b1, 16'd4);
    begin
      int n;
      n = 0;
      while (!trx_tx_data_oe_o && n < 100) begin
        @(negedge clk); #1;
        n++;
      end
    end
    rst_ni = 1'b0;
    #1;
    check("mid_rst_cs", trx_cs_o, 2'b00);
    check("mid_rst_cs_ena", trx_cs_ena_o, 1'b0);
    check("mid_rst_ready", cmd_ready_o, 1'b1);
    check("mid_rst_clk", trx_tx_clk_ena_o, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    send_cmd(CaRd, 1'b1, 16'd4);
    wait_end("post_rst", 500);
    check_read("post_rst", 1'b1, 4, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
